tri_bus_arbiter: RTL

//  Owns the shared tri-state bus: grants one of N requesters at a time and drives
//  the per-requester output-enable vector that feeds the tristate driver cells.

---
 rtl/tri_bus_pkg.sv | 25 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/tri_bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tri_bus_pkg.sv
// ---------------------------------------------------------------------------
// tri_bus_pkg
//   Shared types and width helpers for the tri-state bus arbiter.
//   - bus_state_t : arbiter FSM states (IDLE / DRIVE / TURN)
//   - DEF_*       : default parameter values used by the arbiter
//   - cnt_width() : bit width needed to hold a counter value 0..max_val
// ---------------------------------------------------------------------------
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } bus_state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_MAX_BURST  = 4;
    localparam int DEF_TURNAROUND = 1;

    // Width for a counter that must represent 0..max_val (never less than 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Scans req starting at rr_ptr
//   and wrapping modulo N_REQ; reports the first set bit.
// Ports
//   req    in   N_REQ   request vector
//   rr_ptr in   ID_W    index with highest priority this cycle
//   found  out  1       at least one request is set
//   idx    out  ID_W    index of the winning request (0 when !found)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    // Rotating a doubled copy puts the rr_ptr bit at position 0, so a plain
    // low-to-high scan of the bottom N_REQ bits gives round-robin order.
    logic [2*N_REQ-1:0] req_rot;

    always_comb begin
        int k;
        k       = 0;
        found   = 1'b0;
        idx     = '0;
        req_rot = {req, req} >> rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!found && req_rot[i]) begin
                found = 1'b1;
                idx   = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tri_bus_arbiter
//   Owns a shared tri-state bus. Grants one requester at a time, drives the
//   per-driver output enables (oe == grant), bounds each ownership to
//   MAX_BURST cycles, and forces TURNAROUND all-off cycles between owners.
// Ports
//   clk         in   1        rising-edge clock
//   reset_n     in   1        synchronous, active-low reset
//   req         in   N_REQ    level request per driver
//   grant       out  N_REQ    one-hot0 registered grant
//   oe          out  N_REQ    one-hot0 registered tristate enables (== grant)
//   owner_id    out  ID_W     index of current / most recent owner
//   bus_busy    out  1        high while in DRIVE
//   overlap_err out  1        sticky flag: oe was seen with more than one bit set
// ---------------------------------------------------------------------------
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         oe,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     bus_busy,
    output logic                     overlap_err
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int BURST_W = cnt_width(MAX_BURST);
    localparam int TURN_W  = cnt_width(TURNAROUND);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [TURN_W-1:0]  TURN_LAST  = TURN_W'(TURNAROUND - 1);
    localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   ONE_HOT0   = N_REQ'(1);

    bus_state_t         state;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   oe_q;
    logic [ID_W-1:0]    owner_id_q;
    logic               bus_busy_q;
    logic               overlap_err_q;
    logic [ID_W-1:0]    rr_ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic [TURN_W-1:0]  turn_cnt;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [N_REQ-1:0]   pick_onehot;
    logic               arb_now;
    logic               drive_end;
    logic [ID_W-1:0]    rr_ptr_next;
    logic               oe_multi;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        pick_onehot = ONE_HOT0 << pick_idx;
        // Arbitration happens in IDLE and on the final TURN cycle only, so a
        // request that toggles earlier inside TURN is never seen.
        arb_now     = (state == ST_IDLE) ||
                      ((state == ST_TURN) && (turn_cnt == TURN_LAST));
        drive_end   = !req[owner_id_q] || (burst_cnt == BURST_LAST);
        rr_ptr_next = (owner_id_q == LAST_ID) ? '0 : owner_id_q + 1'b1;
        // x & (x-1) clears the lowest set bit; non-zero means two or more bits.
        oe_multi    = (oe_q & (oe_q - 1'b1)) != '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            grant_q       <= '0;
            oe_q          <= '0;
            owner_id_q    <= '0;
            bus_busy_q    <= 1'b0;
            overlap_err_q <= 1'b0;
            rr_ptr        <= '0;
            burst_cnt     <= '0;
            turn_cnt      <= '0;
        end else begin
            if (oe_multi) begin
                overlap_err_q <= 1'b1;
            end

            if (arb_now) begin
                if (pick_found) begin
                    state      <= ST_DRIVE;
                    grant_q    <= pick_onehot;
                    oe_q       <= pick_onehot;
                    owner_id_q <= pick_idx;
                    bus_busy_q <= 1'b1;
                    burst_cnt  <= '0;
                end else begin
                    state      <= ST_IDLE;
                    grant_q    <= '0;
                    oe_q       <= '0;
                    bus_busy_q <= 1'b0;
                end
            end else if (state == ST_TURN) begin
                turn_cnt <= turn_cnt + 1'b1;
            end else if (state == ST_DRIVE) begin
                if (drive_end) begin
                    // Enables drop on the same edge the owner is released, so the
                    // TURN cycles that follow are guaranteed all-off.
                    state      <= ST_TURN;
                    grant_q    <= '0;
                    oe_q       <= '0;
                    bus_busy_q <= 1'b0;
                    rr_ptr     <= rr_ptr_next;
                    turn_cnt   <= '0;
                end else begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                // Unused encoding: fall back to a safe, bus-released IDLE.
                state      <= ST_IDLE;
                grant_q    <= '0;
                oe_q       <= '0;
                bus_busy_q <= 1'b0;
            end
        end
    end

    assign grant       = grant_q;
    assign oe          = oe_q;
    assign owner_id    = owner_id_q;
    assign bus_busy    = bus_busy_q;
    assign overlap_err = overlap_err_q;

endmodule
